// File: rtl/systolic_array_controller.sv
// Sequencer for an output-stationary ROWS x COLS systolic array: clears the PEs,
// feeds diagonally skewed operands for K + ROWS + COLS - 2 cycles, then reads out rows.
module systolic_array_controller #(
    parameter int ROWS          = 4,
    parameter int COLS          = 4,
    parameter int K_WIDTH       = 8,
    parameter int STEP_WIDTH    = 10,
    parameter int ROW_IDX_WIDTH = 2
) (
    input  logic                     CLK,
    input  logic                     SYNC_RST,
    input  logic                     Start,
    input  logic [K_WIDTH-1:0]       K_Len,
    output logic                     Busy,
    output logic                     Done,
    output logic                     PE_Clear,
    output logic                     PE_EN,
    output logic [STEP_WIDTH-1:0]    Step,
    output logic [ROWS-1:0]          Row_Valid,
    output logic [COLS-1:0]          Col_Valid,
    output logic                     Result_Valid,
    output logic [ROW_IDX_WIDTH-1:0] Result_Row
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COMPUTE,
        READOUT,
        DONE
    } state_t;

    localparam logic [STEP_WIDTH-1:0]    SKEW_CYCLES = STEP_WIDTH'(ROWS + COLS - 2);
    localparam logic [STEP_WIDTH-1:0]    STEP_ONE    = STEP_WIDTH'(1);
    localparam logic [ROW_IDX_WIDTH-1:0] LAST_ROW    = ROW_IDX_WIDTH'(ROWS - 1);
    localparam logic [ROW_IDX_WIDTH-1:0] ROW_ONE     = ROW_IDX_WIDTH'(1);

    state_t                     state;
    state_t                     next_state;
    logic [K_WIDTH-1:0]         k_reg;
    logic [STEP_WIDTH-1:0]      step_reg;
    logic [STEP_WIDTH-1:0]      last_step;
    logic [STEP_WIDTH-1:0]      k_ext;
    logic [ROW_IDX_WIDTH-1:0]   row_reg;

    // Last compute index T-1; only consulted in COMPUTE, where K is at least 1.
    assign k_ext     = STEP_WIDTH'(k_reg);
    assign last_step = k_ext + SKEW_CYCLES - STEP_ONE;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = CLEAR;
            CLEAR:   next_state = (k_reg == '0) ? READOUT : COMPUTE;
            COMPUTE: if (step_reg == last_step) next_state = READOUT;
            READOUT: if (row_reg == LAST_ROW) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Step holds its final value after COMPUTE so the buffers see a stable index.
    always_ff @(posedge CLK) begin
        if (SYNC_RST) begin
            state    <= IDLE;
            k_reg    <= '0;
            step_reg <= '0;
            row_reg  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (Start) begin
                        k_reg    <= K_Len;
                        step_reg <= '0;
                    end
                end
                COMPUTE: begin
                    if (step_reg != last_step) step_reg <= step_reg + STEP_ONE;
                end
                READOUT: begin
                    row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + ROW_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Busy         = (state != IDLE);
        Done         = (state == DONE);
        PE_Clear     = (state == CLEAR);
        PE_EN        = (state == COMPUTE);
        Result_Valid = (state == READOUT);
        Step         = step_reg;
        Result_Row   = row_reg;
    end

    // Stream r (or c) carries element Step - r, valid only while that index lies in [0, K).
    always_comb begin
        Row_Valid = '0;
        Col_Valid = '0;
        for (int r = 0; r < ROWS; r++) begin
            Row_Valid[r] = (state == COMPUTE) &&
                           (step_reg >= STEP_WIDTH'(r)) &&
                           ((step_reg - STEP_WIDTH'(r)) < k_ext);
        end
        for (int c = 0; c < COLS; c++) begin
            Col_Valid[c] = (state == COMPUTE) &&
                           (step_reg >= STEP_WIDTH'(c)) &&
                           ((step_reg - STEP_WIDTH'(c)) < k_ext);
        end
    end

endmodule
